// File: rtl/tmds_encoder_dvi.sv
// tmds_encoder_dvi: two-stage pipelined DVI TMDS encoder, one symbol per clock.
// Define TMDS_OUT_REG_EN to add an output register stage (latency 3).
module tmds_encoder_dvi (
  input  logic       clk_pix,
  input  logic       rst_pix,
  input  logic       de,
  input  logic [7:0] din,
  input  logic [1:0] ctrl,
  output logic [9:0] tmds,
  output logic [5:0] bias
);

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;

  logic       r_de;
  logic [1:0] r_ctrl;
  logic [8:0] r_qm;
  logic [3:0] w_n1d;
  logic       w_xnor;
  logic [8:0] w_qm;

  always_comb begin
    w_n1d = 4'd0;
    for (int i = 0; i < 8; i++)
      w_n1d = w_n1d + {3'd0, din[i]};
  end

  assign w_xnor = (w_n1d > 4'd4) ||
                  (w_n1d == 4'd4 && !din[0]);

  // XNOR is XOR with an extra inversion
  always_comb begin
    logic [8:0] v;
    v    = 9'd0;
    v[0] = din[0];
    for (int i = 1; i < 8; i++)
      v[i] = v[i-1] ^ din[i] ^ w_xnor;
    v[8] = ~w_xnor;
    w_qm = v;
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_de   <= 1'b0;
      r_ctrl <= 2'b00;
      r_qm   <= 9'd0;
    end else begin
      r_de   <= de;
      r_ctrl <= ctrl;
      r_qm   <= w_qm;
    end
  end

  logic [3:0]        w_n1q;
  logic signed [5:0] w_diff;
  logic signed [5:0] w_dcnt;
  logic [9:0]        w_sym;
  logic [9:0]        w_tok;
  logic [9:0]        r_tmds;
  logic signed [5:0] r_cnt;

  always_comb begin
    w_n1q = 4'd0;
    for (int i = 0; i < 8; i++)
      w_n1q = w_n1q + {3'd0, r_qm[i]};
  end

  // n1q - n0q == 2*n1q - 8
  assign w_diff = $signed({1'b0, w_n1q, 1'b0}) - 6'sd8;

  always_comb begin
    w_sym  = TOK00;
    w_dcnt = 6'sd0;
    if (r_cnt == 6'sd0 || w_n1q == 4'd4) begin
      w_sym  = {~r_qm[8], r_qm[8],
                r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
      w_dcnt = r_qm[8] ? w_diff : -w_diff;
    end else if ((!r_cnt[5] && w_n1q > 4'd4) ||
                 (r_cnt[5] && w_n1q < 4'd4)) begin
      w_sym  = {1'b1, r_qm[8], ~r_qm[7:0]};
      w_dcnt = $signed({4'd0, r_qm[8], 1'b0}) - w_diff;
    end else begin
      w_sym  = {1'b0, r_qm[8], r_qm[7:0]};
      w_dcnt = w_diff - $signed({4'd0, ~r_qm[8], 1'b0});
    end
  end

  always_comb begin
    w_tok = TOK00;
    unique case (r_ctrl)
      2'b00: w_tok = TOK00;
      2'b01: w_tok = TOK01;
      2'b10: w_tok = TOK10;
      2'b11: w_tok = TOK11;
    endcase
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_tmds <= TOK00;
      r_cnt  <= 6'sd0;
    end else if (!r_de) begin
      r_tmds <= w_tok;
      r_cnt  <= 6'sd0;
    end else begin
      r_tmds <= w_sym;
      r_cnt  <= r_cnt + w_dcnt;
    end
  end

`ifdef TMDS_OUT_REG_EN
  logic [9:0] r_tmds_o;
  logic [5:0] r_bias_o;

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_tmds_o <= TOK00;
      r_bias_o <= 6'd0;
    end else begin
      r_tmds_o <= r_tmds;
      r_bias_o <= r_cnt;
    end
  end

  assign tmds = r_tmds_o;
  assign bias = r_bias_o;
`else
  assign tmds = r_tmds;
  assign bias = r_cnt;
`endif

endmodule
